traffic_ctrl_gen: RTL and testbench
===================================

TRAFFIC_CTRL_GEN -- requirements
Module: traffic_ctrl_gen

Interface
REQ-001 Parameter TICK_DIV, default 8000000: clk cycles per countdown tick, at least 2.
REQ-002 Parameter GREEN_A, default 35: main-road green duration in ticks, 1..99.
REQ-003 Parameter GREEN_B, default 25: side-road green duration in ticks, 1..99.
REQ-004 Parameter YELLOW, default 5: yellow duration in ticks for either road, 1..99.
REQ-005 Parameter ALL_RED, default 2: all-red clearance duration in ticks, 1..99.
REQ-006 Parameter PED_MIN, default 5: remaining main-green ticks after a pedestrian request is granted; PED_MIN < GREEN_A.
REQ-007 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-008 Port clr  in  1: reset, asynchronous, active-high.
REQ-009 Port pause  in  1: freezes the countdown while high.
REQ-010 Port stopa  in  1: main-road stop; forces A red and B green.
REQ-011 Port stopb  in  1: side-road stop; forces A green and B red.
REQ-012 Port ped_req  in  1: pedestrian crossing request on the main road, level-sampled.
REQ-013 Port light1  out  3: main-road lamps; red=100, green=010, yellow=001.
REQ-014 Port light2  out  3: side-road lamps; same encoding as light1.
REQ-015 Port data  out  8: BCD count of remaining ticks in the current phase; [7:4] tens, [3:0] units.
REQ-016 Port phase  out  3: current phase code.
REQ-017 Port ped_ack  out  1: one-cycle pulse when a pending pedestrian request is consumed.

Function
REQ-018 Phases and lamps (light1/light2): AR_A 100/100, A_GRN 010/100, A_YEL 001/100, AR_B 100/100, B_GRN 100/010, B_YEL 100/001, F_BGO 100/010, F_AGO 010/100.
REQ-019 Normal cycle: AR_A -> A_GRN -> A_YEL -> AR_B -> B_GRN -> B_YEL -> AR_A.
REQ-020 Phase durations: AR_x = ALL_RED, A_GRN = GREEN_A, B_GRN = GREEN_B, x_YEL = YELLOW ticks.
REQ-021 Tick: tick_gen pulses for one clk every TICK_DIV clocks; the first pulse comes TICK_DIV clocks after clr falls.
REQ-022 Countdown: on a tick with pause=0 and no force, data==1 loads the next phase duration and enters the next phase; any other value decrements data in BCD (units 0 -> 9 with a tens borrow).
REQ-023 A phase of duration D shows D, D-1, ..., 1, lasting exactly D ticks.
REQ-024 Phase, lamps and data are registered and change on the same edge.
REQ-025 pause=1 holds data and phase; ticks during pause are lost. The prescaler keeps running.
REQ-026 stopa=1 enters F_BGO on the next edge from any phase, including on a non-tick cycle. stopb=1 enters F_AGO the same way.
REQ-027 If stopa and stopb are both high, stopa wins. Force overrides pause.
REQ-028 While forced, data holds 00.
REQ-029 Leaving force: F_BGO goes to B_YEL and F_AGO goes to A_YEL, each loading YELLOW; a direct stop switch goes straight to the other force phase.
REQ-030 ped_req=1 sets ped_pend.
REQ-031 In A_GRN with ped_pend set: if data > PED_MIN, load data with PED_MIN. Whether or not data is loaded, clear ped_pend and pulse ped_ack. This takes one clock and is independent of tick.
REQ-032 ped_pend set outside A_GRN persists until the next A_GRN.
REQ-033 A ped grant and a tick on the same edge: the grant wins and the tick decrement is skipped.
REQ-034 A clr assertion mid-phase or mid-force aborts immediately and leaves no residual pending request.

Reset
REQ-035 clr=1 asynchronously sets phase=AR_A, data=BCD(ALL_RED), light1=100, light2=100, ped_pend=0, ped_ack=0 and clears the prescaler.

Structure
REQ-036 Package traffic_pkg SHALL hold the phase codes, the lamp codes (RED/GRN/YEL) and the binary-to-BCD constant function used for parameter loads.
REQ-037 Sub-module tick_gen(TICK_DIV) SHALL own the prescaler counter; clog2-sized, clr-cleared.
REQ-038 Elaboration SHALL fail when any duration is outside 1..99 or PED_MIN >= GREEN_A.

Verification
REQ-039 Bench parameters: TICK_DIV=4, GREEN_A=12, GREEN_B=8, YELLOW=3, ALL_RED=2, PED_MIN=5.
REQ-040 Full cycle with no inputs: dwell ticks are 2, 12, 3, 2, 8, 3; data shows 12, 11, 10, 09, ..., 01 in A_GRN; the lamp pairs follow REQ-018.
REQ-041 ped_req pulse at A_GRN data=10: next edge data=05 with a one-cycle ped_ack. A pulse at data=04: ack pulses and data stays at 04.
REQ-042 stopa during A_GRN data=07: next edge gives F_BGO (100/010) and data=00. On release: B_YEL, data=03, then AR_A.
REQ-043 stopa and stopb both high: F_BGO. Drop stopa with stopb held: F_AGO. Drop stopb: A_YEL.
REQ-044 pause for 20 clocks in B_GRN data=06: data stays 06. After release it decrements on the next tick.
REQ-045 clr pulse mid-A_YEL with ped_pend set: immediately AR_A, data=02, lamps 100/100, and no ack in the next A_GRN.

Source files
------------

// File: rtl/traffic_ctrl_gen_pkg.sv
// Shared phase/lamp encodings and BCD helpers for the two-road traffic controller.
package traffic_pkg;

    localparam logic [2:0] PH_AR_A  = 3'd0;
    localparam logic [2:0] PH_A_GRN = 3'd1;
    localparam logic [2:0] PH_A_YEL = 3'd2;
    localparam logic [2:0] PH_AR_B  = 3'd3;
    localparam logic [2:0] PH_B_GRN = 3'd4;
    localparam logic [2:0] PH_B_YEL = 3'd5;
    localparam logic [2:0] PH_F_BGO = 3'd6;
    localparam logic [2:0] PH_F_AGO = 3'd7;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b001;

    typedef struct packed {
        logic [2:0] l1;
        logic [2:0] l2;
    } lamps_t;

    // Constant-foldable conversion used for parameter loads (0..99 only).
    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic lamps_t lamps_of(input logic [2:0] ph);
        lamps_t l;
        case (ph)
            PH_A_GRN: l = '{l1: GRN, l2: RED};
            PH_A_YEL: l = '{l1: YEL, l2: RED};
            PH_B_GRN: l = '{l1: RED, l2: GRN};
            PH_B_YEL: l = '{l1: RED, l2: YEL};
            PH_F_BGO: l = '{l1: RED, l2: GRN};
            PH_F_AGO: l = '{l1: GRN, l2: RED};
            default:  l = '{l1: RED, l2: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_ctrl_gen_tick.sv
// Prescaler: one-clock tick every TICK_DIV clocks, restarted by clr.
module tick_gen #(
    parameter int unsigned TICK_DIV = 8000000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // The edge that consumes this pulse is the TICK_DIV-th edge after clr falls.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_ctrl_gen.sv
// Two-road traffic light controller with BCD countdown, force stops and pedestrian shortening.
module traffic_ctrl_gen
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8000000,
    parameter int unsigned GREEN_A  = 35,
    parameter int unsigned GREEN_B  = 25,
    parameter int unsigned YELLOW   = 5,
    parameter int unsigned ALL_RED  = 2,
    parameter int unsigned PED_MIN  = 5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pause,
    input  logic       stopa,
    input  logic       stopb,
    input  logic       ped_req,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [7:0] data,
    output logic [2:0] phase,
    output logic       ped_ack
);

    if (TICK_DIV < 2 ||
        GREEN_A < 1 || GREEN_A > 99 || GREEN_B < 1 || GREEN_B > 99 ||
        YELLOW  < 1 || YELLOW  > 99 || ALL_RED < 1 || ALL_RED > 99 ||
        PED_MIN >= GREEN_A) begin : g_bad_params
        $error("traffic_ctrl_gen: parameter out of range");
    end

    localparam logic [7:0] D_GA  = to_bcd(GREEN_A);
    localparam logic [7:0] D_GB  = to_bcd(GREEN_B);
    localparam logic [7:0] D_Y   = to_bcd(YELLOW);
    localparam logic [7:0] D_AR  = to_bcd(ALL_RED);
    localparam logic [7:0] D_PED = to_bcd(PED_MIN);

    logic       tick;
    logic       ped_pend;
    logic       grant;
    logic [2:0] nxt_phase;
    logic [7:0] nxt_data;
    lamps_t     nxt_lamps;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    // A request arriving in A_GRN is granted on the same edge it is seen.
    assign grant = (phase == PH_A_GRN) && (ped_pend || ped_req) && !stopa && !stopb;

    always_comb begin
        nxt_phase = phase;
        nxt_data  = data;
        if (stopa) begin
            nxt_phase = PH_F_BGO;
            nxt_data  = 8'h00;
        end else if (stopb) begin
            nxt_phase = PH_F_AGO;
            nxt_data  = 8'h00;
        end else if (phase == PH_F_BGO) begin
            nxt_phase = PH_B_YEL;
            nxt_data  = D_Y;
        end else if (phase == PH_F_AGO) begin
            nxt_phase = PH_A_YEL;
            nxt_data  = D_Y;
        end else if (grant) begin
            if (data > D_PED)
                nxt_data = D_PED;
        end else if (tick && !pause) begin
            if (data == 8'h01) begin
                case (phase)
                    PH_AR_A:  begin nxt_phase = PH_A_GRN; nxt_data = D_GA; end
                    PH_A_GRN: begin nxt_phase = PH_A_YEL; nxt_data = D_Y;  end
                    PH_A_YEL: begin nxt_phase = PH_AR_B;  nxt_data = D_AR; end
                    PH_AR_B:  begin nxt_phase = PH_B_GRN; nxt_data = D_GB; end
                    PH_B_GRN: begin nxt_phase = PH_B_YEL; nxt_data = D_Y;  end
                    default:  begin nxt_phase = PH_AR_A;  nxt_data = D_AR; end
                endcase
            end else begin
                nxt_data = bcd_dec(data);
            end
        end
    end

    assign nxt_lamps = lamps_of(nxt_phase);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            phase    <= PH_AR_A;
            data     <= D_AR;
            light1   <= RED;
            light2   <= RED;
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            phase    <= nxt_phase;
            data     <= nxt_data;
            light1   <= nxt_lamps.l1;
            light2   <= nxt_lamps.l2;
            ped_pend <= grant ? 1'b0 : (ped_pend | ped_req);
            ped_ack  <= grant;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// Randomised and directed checks of traffic_ctrl_gen against an integer reference model.
module tb_traffic_ctrl_gen;
    import traffic_pkg::*;

    localparam int TD = 4, GA = 12, GB = 8, YL = 3, AR = 2, PM = 5;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       pause = 1'b0, stopa = 1'b0, stopb = 1'b0, ped_req = 1'b0;
    logic [2:0] light1, light2, phase;
    logic [7:0] data;
    logic       ped_ack;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state: plain integers
    int m_ph, m_rem, m_cnt;
    bit m_pend, m_ack;

    traffic_ctrl_gen #(.TICK_DIV(TD), .GREEN_A(GA), .GREEN_B(GB), .YELLOW(YL),
                       .ALL_RED(AR), .PED_MIN(PM)) dut (
        .clk(clk), .clr(clr), .pause(pause), .stopa(stopa), .stopb(stopb),
        .ped_req(ped_req), .light1(light1), .light2(light2), .data(data),
        .phase(phase), .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    wire [17:0] dut_vec = {phase, data, light1, light2, ped_ack};

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int dur_of(input int ph);
        case (ph)
            PH_A_GRN: return GA;
            PH_B_GRN: return GB;
            PH_A_YEL, PH_B_YEL: return YL;
            default: return AR;
        endcase
    endfunction

    function automatic int next_of(input int ph);
        case (ph)
            PH_AR_A:  return PH_A_GRN;
            PH_A_GRN: return PH_A_YEL;
            PH_A_YEL: return PH_AR_B;
            PH_AR_B:  return PH_B_GRN;
            PH_B_GRN: return PH_B_YEL;
            default:  return PH_AR_A;
        endcase
    endfunction

    function automatic logic [5:0] lamps_exp(input int ph);
        case (ph)
            PH_A_GRN, PH_F_AGO: return 6'b010_100;
            PH_A_YEL:           return 6'b001_100;
            PH_B_GRN, PH_F_BGO: return 6'b100_010;
            PH_B_YEL:           return 6'b100_001;
            default:            return 6'b100_100;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec();
        return {3'(m_ph), bcd(m_rem), lamps_exp(m_ph), m_ack};
    endfunction

    task automatic model_reset();
        m_ph = PH_AR_A; m_rem = AR; m_cnt = 0; m_pend = 0; m_ack = 0;
    endtask

    // Advance the model with the inputs present at the coming edge, then clock the DUT.
    task automatic step();
        bit tk, gr;
        if (clr) begin
            model_reset();
        end else begin
            tk = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            gr = 0;
            if (stopa) begin m_ph = PH_F_BGO; m_rem = 0; end
            else if (stopb) begin m_ph = PH_F_AGO; m_rem = 0; end
            else if (m_ph == PH_F_BGO) begin m_ph = PH_B_YEL; m_rem = YL; end
            else if (m_ph == PH_F_AGO) begin m_ph = PH_A_YEL; m_rem = YL; end
            else if (m_ph == PH_A_GRN && (m_pend || ped_req)) begin
                gr = 1;
                if (m_rem > PM) m_rem = PM;
            end else if (tk && !pause) begin
                if (m_rem == 1) begin m_ph = next_of(m_ph); m_rem = dur_of(m_ph); end
                else m_rem = m_rem - 1;
            end
            m_ack = gr;
            m_pend = gr ? 1'b0 : (m_pend | ped_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input logic [2:0] ph, input logic [7:0] d, input bit any_d,
                            input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (phase === ph && (any_d || data === d)) begin ok = 1; return; end
            step();
        end
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (phase !== PH_AR_A) begin n_fail++; $display("FAIL reset_phase got %0d want %0d", phase, PH_AR_A); end
        n_cmp++; if (data !== 8'h02) begin n_fail++; $display("FAIL reset_data got %h want 02", data); end
        n_cmp++; if (light1 !== 3'b100) begin n_fail++; $display("FAIL reset_light1 got %b want 100", light1); end
        n_cmp++; if (light2 !== 3'b100) begin n_fail++; $display("FAIL reset_light2 got %b want 100", light2); end
        n_cmp++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ped_ack); end
        step();
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_full_cycle();
        int want[6] = '{2, 12, 3, 2, 8, 3};
        logic [2:0] prev;
        int cyc, rec;
        prev = phase; cyc = 0; rec = 0;
        for (int i = 0; i < 400 && rec < 6; i++) begin
            step();
            cyc++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL cycle_vec got %h want %h", dut_vec, exp_vec());
            end
            if (phase !== prev) begin
                n_cmp++;
                if (cyc !== want[rec] * TD) begin
                    n_fail++; $display("FAIL dwell_%0d got %0d clocks want %0d", rec, cyc, want[rec] * TD);
                end
                rec++; cyc = 0; prev = phase;
            end
        end
        n_cmp++; if (rec !== 6) begin n_fail++; $display("FAIL cycle_timeout got %0d phases want 6", rec); end
    endtask

    task automatic test_ped();
        bit ok;
        wait_for(PH_A_GRN, 8'h10, 0, 400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ped_wait10 got timeout want A_GRN/10"); end
        ped_req = 1'b1; step(); ped_req = 1'b0;
        n_cmp++; if (data !== 8'h05) begin n_fail++; $display("FAIL ped_load got %h want 05", data); end
        n_cmp++; if (ped_ack !== 1'b1) begin n_fail++; $display("FAIL ped_ack got %b want 1", ped_ack); end
        step();
        n_cmp++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL ped_ack_pulse got %b want 0", ped_ack); end
        wait_for(PH_A_GRN, 8'h04, 0, 40, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ped_wait04 got timeout want A_GRN/04"); end
        ped_req = 1'b1; step(); ped_req = 1'b0;
        n_cmp++; if (data !== 8'h04 || ped_ack !== 1'b1) begin
            n_fail++; $display("FAIL ped_low got %h/%b want 04/1", data, ped_ack);
        end
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ped_vec got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_force();
        bit ok;
        wait_for(PH_A_GRN, 8'h07, 0, 400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL force_wait got timeout want A_GRN/07"); end
        stopa = 1'b1; step();
        n_cmp++; if (phase !== PH_F_BGO || data !== 8'h00 || {light1, light2} !== 6'b100_010) begin
            n_fail++; $display("FAIL force_bgo got %0d/%h/%b%b want 6/00/100010", phase, data, light1, light2);
        end
        for (int i = 0; i < 9; i++) step();
        n_cmp++; if (data !== 8'h00 || phase !== PH_F_BGO) begin n_fail++; $display("FAIL force_hold got %0d/%h want 6/00", phase, data); end
        stopa = 1'b0; step();
        n_cmp++; if (phase !== PH_B_YEL || data !== 8'h03) begin n_fail++; $display("FAIL force_rel got %0d/%h want 5/03", phase, data); end
        wait_for(PH_AR_A, 8'h00, 1, 20, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL force_to_ara got timeout want AR_A"); end
        stopa = 1'b1; stopb = 1'b1; step();
        n_cmp++; if (phase !== PH_F_BGO) begin n_fail++; $display("FAIL force_both got %0d want 6", phase); end
        stopa = 1'b0; step();
        n_cmp++; if (phase !== PH_F_AGO || {light1, light2} !== 6'b010_100) begin
            n_fail++; $display("FAIL force_ago got %0d/%b%b want 7/010100", phase, light1, light2);
        end
        stopb = 1'b0; step();
        n_cmp++; if (phase !== PH_A_YEL || data !== 8'h03) begin n_fail++; $display("FAIL force_ayel got %0d/%h want 2/03", phase, data); end
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL force_vec got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_pause();
        bit ok;
        int n;
        wait_for(PH_B_GRN, 8'h06, 0, 400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL pause_wait got timeout want B_GRN/06"); end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (data !== 8'h06 || phase !== PH_B_GRN) begin n_fail++; $display("FAIL pause_hold got %0d/%h want 4/06", phase, data); end
        pause = 1'b0;
        n = 0;
        while (data === 8'h06 && n < TD + 2) begin step(); n++; end
        n_cmp++; if (data !== 8'h05 || n > TD) begin n_fail++; $display("FAIL pause_resume got %h after %0d clocks want 05 within %0d", data, n, TD); end
    endtask

    task automatic test_clr();
        bit ok, seen;
        wait_for(PH_A_YEL, 8'h00, 1, 400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL clr_wait got timeout want A_YEL"); end
        ped_req = 1'b1; step(); ped_req = 1'b0;
        #3 clr = 1'b1;
        #1;
        n_cmp++; if (phase !== PH_AR_A || data !== 8'h02 || {light1, light2} !== 6'b100_100) begin
            n_fail++; $display("FAIL clr_async got %0d/%h/%b%b want 0/02/100100", phase, data, light1, light2);
        end
        step();
        clr = 1'b0;
        model_reset();
        wait_for(PH_A_GRN, 8'h00, 1, 40, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL clr_to_agrn got timeout want A_GRN"); end
        seen = 0;
        for (int i = 0; i < 100 && phase === PH_A_GRN; i++) begin
            if (ped_ack === 1'b1) seen = 1;
            step();
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_no_ack got ack=%b want 0", seen); end
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL clr_vec got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pause   = ($urandom_range(0, 99) < 8);
            stopa   = ($urandom_range(0, 99) < 2) ? ~stopa : stopa;
            stopb   = ($urandom_range(0, 99) < 2) ? ~stopb : stopb;
            ped_req = ($urandom_range(0, 99) < 3);
            clr     = ($urandom_range(0, 999) < 3);
            step();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        clr = 1'b0; pause = 1'b0; stopa = 1'b0; stopb = 1'b0; ped_req = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_cycle();
        test_ped();
        test_force();
        test_pause();
        test_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
